// File: rtl/vga_pkg.sv
// Shared VGA timing constants: 1024x768@60 and 640x480@60 sets, sync polarity codes.
package vga_pkg;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  localparam int unsigned XGA_H_VIS  = 1024;
  localparam int unsigned XGA_H_FP   = 24;
  localparam int unsigned XGA_H_SYNC = 136;
  localparam int unsigned XGA_H_BP   = 160;
  localparam int unsigned XGA_V_VIS  = 768;
  localparam int unsigned XGA_V_FP   = 3;
  localparam int unsigned XGA_V_SYNC = 6;
  localparam int unsigned XGA_V_BP   = 29;

  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  // Pin level for a sync that is logically active/inactive under polarity pol.
  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and the framebuffer read side.
interface vga_timing_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          en;
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic          vblank;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] line_y;
  logic          sol;
  logic          sof;

  modport master (
    input  en,
    output h_sync, v_sync, de, vblank, pixel_x, line_y, sol, sof
  );

  modport slave (
    output en,
    input  h_sync, v_sync, de, vblank, pixel_x, line_y, sol, sof
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: counter over visible/front porch/sync/back porch plus region decode.
module vga_axis_cnt #(
  parameter int unsigned VIS    = 1024,
  parameter int unsigned FP     = 24,
  parameter int unsigned SYNC   = 136,
  parameter int unsigned BP     = 160,
  parameter int unsigned WIN0   = 0,
  parameter int unsigned WINLEN = 1024,
  parameter int unsigned WW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  output logic          o_wrap,
  output logic          o_sync,
  output logic          o_in_win,
  output logic          o_blank,
  output logic [WW-1:0] o_pos
);
  localparam int unsigned TOTAL = VIS + FP + SYNC + BP;
  localparam int unsigned CW    = $clog2(TOTAL);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_win_off;
  logic [CW-1:0] w_sync_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  // Offsets wrap below the region start, so one unsigned compare covers both bounds.
  always_comb begin
    w_win_off  = r_cnt - CW'(WIN0);
    w_sync_off = r_cnt - CW'(VIS + FP);
    o_wrap     = i_inc & (r_cnt == CW'(TOTAL - 1));
    o_sync     = w_sync_off < CW'(SYNC);
    o_in_win   = w_win_off < CW'(WINLEN);
    o_blank    = r_cnt >= CW'(VIS);
    o_pos      = o_in_win ? WW'(w_win_off) : '0;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a programmable display window.
// Define VGA_TIMING_PREFETCH_EN to make coordinates/strobes lead de and syncs by 2 pixels.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS    = XGA_H_VIS,
  parameter int unsigned H_FP     = XGA_H_FP,
  parameter int unsigned H_SYNC   = XGA_H_SYNC,
  parameter int unsigned H_BP     = XGA_H_BP,
  parameter int unsigned V_VIS    = XGA_V_VIS,
  parameter int unsigned V_FP     = XGA_V_FP,
  parameter int unsigned V_SYNC   = XGA_V_SYNC,
  parameter int unsigned V_BP     = XGA_V_BP,
  parameter bit          SYNC_POL = SYNC_ACT_LOW,
  parameter int unsigned WIN_X0   = 0,
  parameter int unsigned WIN_W    = 1024,
  parameter int unsigned WIN_Y0   = 128,
  parameter int unsigned WIN_H    = 512
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga_bus
);
  localparam int unsigned XW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int unsigned YW = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  // Control word layout: {h_sync, v_sync, de, vblank}.
  localparam logic [3:0] CTL_RST = {~SYNC_POL, ~SYNC_POL, 2'b00};

  if (WIN_X0 + WIN_W > H_VIS) begin : g_chk_win_x
    $error("display window exceeds visible pixels");
  end
  if (WIN_Y0 + WIN_H > V_VIS) begin : g_chk_win_y
    $error("display window exceeds visible lines");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_chk_porch
    $error("porch and sync widths must be at least 1");
  end

  logic          w_h_wrap, w_unused_v_wrap, w_unused_h_blank;
  logic          w_h_act, w_v_act, w_in_x, w_in_y, w_vblank;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_ly;
  logic          w_de, w_sol, w_sof;
  logic [3:0]    w_ctl, w_ctl_out;

  vga_axis_cnt #(
    .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .WIN0(WIN_X0), .WINLEN(WIN_W), .WW(XW)
  ) u_h_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (vga_bus.en),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_h_act),
    .o_in_win (w_in_x),
    .o_blank  (w_unused_h_blank),
    .o_pos    (w_px)
  );

  vga_axis_cnt #(
    .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .WIN0(WIN_Y0), .WINLEN(WIN_H), .WW(YW)
  ) u_v_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_h_wrap),
    .o_wrap   (w_unused_v_wrap),
    .o_sync   (w_v_act),
    .o_in_win (w_in_y),
    .o_blank  (w_vblank),
    .o_pos    (w_ly)
  );

  always_comb begin
    w_de  = w_in_x & w_in_y;
    w_sol = w_de & (w_px == '0);
    w_sof = w_sol & (w_ly == '0);
    w_ctl = {sync_level(w_h_act, SYNC_POL), sync_level(w_v_act, SYNC_POL), w_de, w_vblank};
  end

  logic [3:0]    r_ctl;
  logic [XW-1:0] r_pixel_x;
  logic [YW-1:0] r_line_y;
  logic          r_sol, r_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl     <= CTL_RST;
      r_pixel_x <= '0;
      r_line_y  <= '0;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end else if (vga_bus.en) begin
      r_ctl     <= w_ctl;
      r_pixel_x <= w_px;
      r_line_y  <= w_ly;
      r_sol     <= w_sol;
      r_sof     <= w_sof;
    end else begin
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  // Syncs and de trail the coordinates by two pixels to cover the framebuffer read.
  logic [3:0] r_ctl_d1, r_ctl_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_d1 <= CTL_RST;
      r_ctl_d2 <= CTL_RST;
    end else if (vga_bus.en) begin
      r_ctl_d1 <= r_ctl;
      r_ctl_d2 <= r_ctl_d1;
    end
  end

  assign w_ctl_out = r_ctl_d2;
`else
  assign w_ctl_out = r_ctl;
`endif

  assign vga_bus.h_sync  = w_ctl_out[3];
  assign vga_bus.v_sync  = w_ctl_out[2];
  assign vga_bus.de      = w_ctl_out[1];
  assign vga_bus.vblank  = w_ctl_out[0];
  assign vga_bus.pixel_x = r_pixel_x;
  assign vga_bus.line_y  = r_line_y;
  assign vga_bus.sol     = r_sol;
  assign vga_bus.sof     = r_sof;

endmodule
